// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the wait-stated MIPS data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reserved size is always rejected; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Little-endian byte-lane enables for a store of the given size at offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicates right-justified store data into every lane; the mask picks the live ones.
    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pulls the addressed lane down to bit 0 and sign- or zero-extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sign_ext);
        logic        [31:0] shifted;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        shifted = word >> {off, 3'b000};
        b_s     = shifted[7:0];
        h_s     = shifted[15:0];
        case (size)
            SZ_BYTE: ext_s = sign_ext ? 32'(b_s) : $signed({24'h0, shifted[7:0]});
            SZ_HALF: ext_s = sign_ext ? 32'(h_s) : $signed({16'h0, shifted[15:0]});
            default: ext_s = $signed(word);
        endcase
        return $unsigned(ext_s);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 word array with per-byte write enables and a registered read port.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Masked lane write and registered read; the wrapper never asks for both at once.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with valid/ready request and response handshakes and a fixed
// number of wait states between acceptance and the access commit.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rd,
    output logic        err
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] cnt;

    // request stage: fields captured on acceptance
    logic             we_p0;
    logic [1:0]       size_p0;
    logic             sign_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       off_p0;
    logic [31:0]      wd_p0;

    // response stage: fields captured at commit, used to decode rd
    logic             load_p1;
    logic [1:0]       size_p1;
    logic [1:0]       off_p1;
    logic             sign_p1;

    logic             in_idle;
    logic             accept;
    logic             commit;
    logic             cur_we;
    logic [1:0]       cur_size;
    logic             cur_sign;
    logic [IDX_W-1:0] cur_idx;
    logic [1:0]       cur_off;
    logic [31:0]      cur_wd;
    logic             cur_err;
    logic             ram_re;
    logic [3:0]       ram_be;
    logic [31:0]      ram_q;
    logic             unused_addr;

    assign in_idle     = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign unused_addr = ^addr[31:IDX_W+2];

    // With no wait states the commit happens on the acceptance edge itself, so
    // the live request inputs feed the access; otherwise the captured copy does.
    always_comb begin
        cur_we   = in_idle ? we              : we_p0;
        cur_size = in_idle ? size            : size_p0;
        cur_sign = in_idle ? sign_ext        : sign_p0;
        cur_idx  = in_idle ? addr[IDX_W+1:2] : idx_p0;
        cur_off  = in_idle ? addr[1:0]       : off_p0;
        cur_wd   = in_idle ? wd              : wd_p0;
    end

    assign commit  = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd1));
    assign cur_err = misaligned(cur_size, cur_off);
    assign ram_re  = reset_n && commit && !cur_we && !cur_err;
    assign ram_be  = (reset_n && commit && cur_we && !cur_err) ? lane_mask(cur_size, cur_off) : 4'b0000;

    dmem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .be    (ram_be),
        .idx   (cur_idx),
        .wdata (store_lanes(cur_wd, cur_size)),
        .rdata (ram_q)
    );

    // Handshake FSM: accept in IDLE, count down in WAIT, hold the response in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            load_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= WS;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
            if (commit) begin
                err     <= cur_err;
                load_p1 <= !cur_we && !cur_err;
            end
        end
    end

    // Request and response data fields; control bits above gate their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0   <= we;
            size_p0 <= size;
            sign_p0 <= sign_ext;
            idx_p0  <= addr[IDX_W+1:2];
            off_p0  <= addr[1:0];
            wd_p0   <= wd;
        end
        if (commit) begin
            size_p1 <= cur_size;
            off_p1  <= cur_off;
            sign_p1 <= cur_sign;
        end
    end

    // rd is decoded from registered state only, so it changes solely at commit or reset.
    always_comb begin
        rd = 32'h0;
        if (load_p1) begin
            rd = load_extract(ram_q, size_p1, off_p1, sign_p1);
        end
    end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: one instance with no wait states, one with three.
module tb_dmem_wait;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        we        [2];
    logic [1:0]  size      [2];
    logic        sign_ext  [2];
    logic [31:0] addr      [2];
    logic [31:0] wd        [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rd        [2];
    logic        err       [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_wait #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .we(we[0]), .size(size[0]), .sign_ext(sign_ext[0]), .addr(addr[0]), .wd(wd[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rd(rd[0]), .err(err[0])
    );

    dmem_wait #(.DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .we(we[1]), .size(size[1]), .sign_ext(sign_ext[1]), .addr(addr[1]), .wd(wd[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rd(rd[1]), .err(err[1])
    );

    // One request/response round trip with rsp_ready held high; lat counts
    // cycles from acceptance to rsp_valid (capped at 40).
    task automatic txn(input int d, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] data,
                       output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1; we[d] = w; size[d] = sz; sign_ext[d] = sx; addr[d] = a; wd[d] = data;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = rd[d];
        e = err[d];
        @(posedge clk);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({req_ready[d], rsp_valid[d], err[d], rd[d]} !== {3'b100, 32'h0}) begin
                fails++;
                $display("FAIL reset_state[%0d]: rdy=%b vld=%b err=%b rd=%h want 1/0/0/00000000",
                         d, req_ready[d], rsp_valid[d], err[d], rd[d]);
            end
        end
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clk);
        tests++;
        if ({req_ready[0], rsp_valid[0], req_ready[1], rsp_valid[1]} !== 4'b1010) begin
            fails++;
            $display("FAIL reset_release: rdy0=%b vld0=%b rdy1=%b vld1=%b want 1/0/1/0",
                     req_ready[0], rsp_valid[0], req_ready[1], rsp_valid[1]);
        end
    endtask

    task automatic test_word();
        logic [31:0] r; logic e; int lat;
        txn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h0} || lat != 1) begin
            fails++;
            $display("FAIL st_word: err=%b rd=%h lat=%0d want 0/00000000/1", e, r, lat);
        end
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hDEADBEEF} || lat != 1) begin
            fails++;
            $display("FAIL ld_word: err=%b rd=%h lat=%0d want 0/deadbeef/1", e, r, lat);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] r; logic e; int lat;
        txn(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hAAAAAA80, r, e, lat);
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h80ADBEEF}) begin
            fails++;
            $display("FAIL st_byte_merge: err=%b rd=%h want 0/80adbeef", e, r);
        end
        txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hFFFFFF80}) begin
            fails++;
            $display("FAIL ld_byte_sx: err=%b rd=%h want 0/ffffff80", e, r);
        end
        txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h00000080}) begin
            fails++;
            $display("FAIL ld_byte_zx: err=%b rd=%h want 0/00000080", e, r);
        end
        txn(0, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hFFFF80AD}) begin
            fails++;
            $display("FAIL ld_half_hi_sx: err=%b rd=%h want 0/ffff80ad", e, r);
        end
        txn(0, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h0000BEEF}) begin
            fails++;
            $display("FAIL ld_half_lo_zx: err=%b rd=%h want 0/0000beef", e, r);
        end
        txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hFFFFFFBE}) begin
            fails++;
            $display("FAIL ld_byte1_sx: err=%b rd=%h want 0/ffffffbe", e, r);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] r; logic e; int lat;
        txn(0, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'h0BADCAFE, r, e, lat);
        txn(0, 1'b1, SZ_WORD, 1'b0, 32'h15, 32'h12345678, r, e, lat);
        tests++;
        if ({e, r} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL mis_word_err: err=%b rd=%h want 1/00000000", e, r);
        end
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h0BADCAFE}) begin
            fails++;
            $display("FAIL mis_word_kept: err=%b rd=%h want 0/0badcafe", e, r);
        end
        txn(0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h00005555, r, e, lat);
        tests++;
        if ({e, r} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL mis_half_err: err=%b rd=%h want 1/00000000", e, r);
        end
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h80ADBEEF}) begin
            fails++;
            $display("FAIL mis_half_kept: err=%b rd=%h want 0/80adbeef", e, r);
        end
        txn(0, 1'b1, SZ_RSVD, 1'b0, 32'h14, 32'hFFFFFFFF, r, e, lat);
        tests++;
        if ({e, r} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rsvd_err: err=%b rd=%h want 1/00000000", e, r);
        end
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h0BADCAFE}) begin
            fails++;
            $display("FAIL rsvd_kept: err=%b rd=%h want 0/0badcafe", e, r);
        end
        txn(0, 1'b0, SZ_HALF, 1'b1, 32'h13, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL mis_load_err: err=%b rd=%h want 1/00000000", e, r);
        end
    endtask

    task automatic test_alias();
        logic [31:0] r; logic e; int lat;
        txn(0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hCAFEF00D, r, e, lat);
        txn(0, 1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hCAFEF00D}) begin
            fails++;
            $display("FAIL alias_wrap: err=%b rd=%h want 0/cafef00d", e, r);
        end
    endtask

    task automatic test_wait_hold();
        logic [31:0] r; logic e; int lat; int bad;
        txn(1, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h01020304, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'h0} || lat != 4) begin
            fails++;
            $display("FAIL ws3_store: err=%b rd=%h lat=%0d want 0/00000000/4", e, r, lat);
        end
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD; sign_ext[1] = 1'b0; addr[1] = 32'h8;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        bad = 0;
        for (int c = 1; c <= 3; c++) begin
            if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ws3_wait_phase: bad_cycles=%0d want 0", bad);
        end
        tests++;
        if (rsp_valid[1] !== 1'b1) begin
            fails++;
            $display("FAIL ws3_latency: rsp_valid=%b at cycle 4 want 1", rsp_valid[1]);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid[1] !== 1'b1 || rd[1] !== 32'h01020304 || err[1] !== 1'b0 ||
                req_ready[1] !== 1'b0) bad++;
            if (c < 4) @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ws3_hold: unstable_cycles=%0d want 0", bad);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        tests++;
        if ({rsp_valid[1], req_ready[1], rd[1]} !== {2'b01, 32'h01020304}) begin
            fails++;
            $display("FAIL ws3_release: vld=%b rdy=%b rd=%h want 0/1/01020304",
                     rsp_valid[1], req_ready[1], rd[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e; int lat; int seen;
        txn(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hAABBCCDD, r, e, lat);
        txn(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, r, e, lat);
        @(negedge clk);
        req_valid[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 32'h20; wd[1] = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset_n[1] = 1'b0;
        #1;
        tests++;
        if ({req_ready[1], rsp_valid[1], err[1], rd[1]} !== {3'b100, 32'h0}) begin
            fails++;
            $display("FAIL rst_mid_outputs: rdy=%b vld=%b err=%b rd=%h want 1/0/0/00000000",
                     req_ready[1], rsp_valid[1], err[1], rd[1]);
        end
        @(negedge clk);
        reset_n[1] = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_mid_norsp: rsp_valid_cycles=%0d want 0", seen);
        end
        txn(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, r, e, lat);
        tests++;
        if ({e, r} !== {1'b0, 32'hAABBCCDD} || lat != 4) begin
            fails++;
            $display("FAIL rst_mid_old: err=%b rd=%h lat=%0d want 0/aabbccdd/4", e, r, lat);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b0; req_valid[d] = 1'b0; we[d] = 1'b0; size[d] = SZ_WORD;
            sign_ext[d] = 1'b0; addr[d] = 32'h0; wd[d] = 32'h0; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_alias();
        test_wait_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_wait.md
Name: dmem_wait

Overview:
- Parametrised data memory for the MIPS processor datapath.
- Word-organised RAM with byte and halfword access, sign/zero extension and misalignment detection.
- Programmable wait-state latency behind a valid/ready request and response handshake.
- Sits between the processor load/store unit and the memory array; this is the block multicycle and stalling cores attach to.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 2..4096.
- WAIT_STATES, 0, extra cycles between request acceptance and response; 0..15.
- IDX_W, clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- we  in  1  1 = store, 0 = load; sampled on acceptance.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wd  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rd  out  32  load result, extended; 0 for stores and errors.
- err  out  1  misaligned or reserved-size access; qualified by rsp_valid.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): state IDLE, req_ready=1, rsp_valid=0, rd=0, err=0, wait counter=0. RAM contents not reset.
- Word index = addr[IDX_W+1:2]; upper address bits ignored, so addresses alias modulo DEPTH*4.
- Byte lanes little-endian: addr[1:0]=0 selects bits [7:0], 3 selects [31:24]. Halfword addr[1]=0 selects [15:0], 1 selects [31:16].
- Misaligned when any of: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11.
- FSM IDLE: req_ready=1.
  - On req_valid&&req_ready, latch we/size/sign_ext/addr/wd, compute err, and load counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- FSM WAIT: req_ready=0; counter decrements each cycle; when counter==1, go to RESP.
- Commit on the clock edge entering RESP. Store with no err writes only the selected byte lanes via a per-lane write mask; other lanes are unchanged. Load with no err registers the extended lane data into rd. When err=1, RAM is untouched and rd=0.
- FSM RESP: rsp_valid=1 and rd/err stable until rsp_ready=1. On the rsp_ready cycle, return to IDLE; rsp_valid drops next cycle.
- Latency: acceptance edge to rsp_valid high is WAIT_STATES+1 cycles. Sustained throughput is one access per WAIT_STATES+2 cycles with rsp_ready tied high.
- No new request is accepted while in WAIT or RESP. req_ready goes high the cycle after the response handshake.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Reset mid-operation:
  - Asserted in WAIT: the pending store is discarded (no RAM change) and there is no response.
  - Asserted in RESP: the response is dropped; the write has already committed.
- rd retains its value while rsp_valid=0 in IDLE. Consumers qualify rd with rsp_valid.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding IDLE/WAIT/RESP;
  - function for lane write mask from size+addr[1:0];
  - function for load extract+extend.
- One natural sub-module, dmem_ram: DEPTH x 32 array with 4-bit byte write enable and synchronous registered read port. The FSM wrapper stays in dmem_wait.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 1 cycle after each acceptance; rd=0xDEADBEEF, err=0.
- Store byte 0x80 @0x13 over the word 0xDEADBEEF at 0x10 -> word becomes 0x80ADBEEF. Load byte @0x13 with sign_ext=1 -> rd=0xFFFFFF80; with sign_ext=0 -> rd=0x00000080. Load half @0x12 with sign_ext=1 -> rd=0xFFFF80AD.
- Misaligned: store word 0x12345678 @0x15 -> err=1, rd=0; a subsequent load word @0x14 returns the prior contents unchanged. Same for half @0x11 and size=11.
- WAIT_STATES=3, rsp_ready held low 5 cycles -> rsp_valid rises 4 cycles after acceptance; rd/err stable for 5 cycles; req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- DEPTH=64: store 0xCAFEF00D @0x100, then load word @0x000 -> 0xCAFEF00D (alias wrap).
- WAIT_STATES=3: reset_n pulsed low during WAIT of a store 0x11111111 @0x20 -> outputs return to reset values immediately; no response; a later load word @0x20 returns the old value.
